mc_ctrl: RTL and testbench

Parametrised multicycle MIPS control unit: a successor to the fixed-latency controller, driving the same datapath control signals (`pcen`, `irwrite`, `regwrite`, mux selects, `alucont`). It adds a memory request/ready handshake with arbitrary wait states, a configurable memory-timeout watchdog, `bne`/`addi`/`j` support, sticky fault reporting and a retired-instruction counter. Sits between the instruction register/decode fields and the datapath inside the `mips` top.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_if.sv | 44 ++++
 rtl/mc_aludec.sv | 24 ++
 rtl/mc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle MIPS controller.
// Holds the state enum, opcode/funct constants, datapath select codes, fault codes.
package mc_pkg;

    typedef logic       u1;
    typedef logic [1:0] u2;
    typedef logic [2:0] u3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_RTEX, S_RTWB, S_BEQEX, S_BNEEX,
        S_ADDIEX, S_ADDIWB, S_JEX, S_FAULT
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam u3 ALU_ADD = 3'b010;
    localparam u3 ALU_SUB = 3'b110;
    localparam u3 ALU_AND = 3'b000;
    localparam u3 ALU_OR  = 3'b001;
    localparam u3 ALU_SLT = 3'b111;

    localparam u2 SRCB_B     = 2'b00;
    localparam u2 SRCB_4     = 2'b01;
    localparam u2 SRCB_IMM   = 2'b10;
    localparam u2 SRCB_IMMSH = 2'b11;

    localparam u2 PC_ALU    = 2'b00;
    localparam u2 PC_ALUOUT = 2'b01;
    localparam u2 PC_JUMP   = 2'b10;

    localparam u2 FC_NONE    = 2'b00;
    localparam u2 FC_ILLEGAL = 2'b01;
    localparam u2 FC_TIMEOUT = 2'b10;

    typedef struct packed {
        u1 mem_req;
        u1 pcen;
        u1 irwrite;
        u1 regwrite;
        u1 memwrite;
        u1 iord;
        u1 alusrca;
        u1 memtoreg;
        u1 regdst;
        u2 alusrcb;
        u2 pcsrc;
        u3 alucont;
    } mc_ctl_t;

    // States in which the controller waits on mem_ready.
    function automatic u1 is_wait(mc_state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: decode fields, memory handshake and datapath controls of mc_ctrl.
// master = controller side (drives controls), slave = datapath/memory side.
interface mc_if #(
    parameter int CNT_W = 32
);
    import mc_pkg::*;

    logic [5:0]       op;
    logic [5:0]       funct;
    u1                zero;
    u1                mem_ready;
    u1                mem_req;
    u1                pcen;
    u1                irwrite;
    u1                regwrite;
    u1                memwrite;
    u1                iord;
    u1                alusrca;
    u1                memtoreg;
    u1                regdst;
    u2                alusrcb;
    u2                pcsrc;
    u3                alucont;
    u1                fault;
    u2                fault_code;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, pcen, irwrite, regwrite, memwrite,
        output iord, alusrca, memtoreg, regdst,
        output alusrcb, pcsrc, alucont,
        output fault, fault_code, instret
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, pcen, irwrite, regwrite, memwrite,
        input  iord, alusrca, memtoreg, regdst,
        input  alusrcb, pcsrc, alucont,
        input  fault, fault_code, instret
    );

endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct field to ALU control, flags unsupported functs.
// Ports: funct in, alucont out, illegal out.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output u3          alucont,
    output u1          illegal
);

    always_comb begin
        alucont = ALU_ADD;
        illegal = 1'b0;
        unique case (funct)
            F_ADD:   alucont = ALU_ADD;
            F_SUB:   alucont = ALU_SUB;
            F_AND:   alucont = ALU_AND;
            F_OR:    alucont = ALU_OR;
            F_SLT:   alucont = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM with memory handshake and watchdog.
// Ports: clk, reset (sync, active-low), bus (mc_if.master).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic  clk,
    input logic  reset,
    mc_if.master bus
);

    localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WLAST =
        WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    mc_state_t        state, state_n;
    logic [WW-1:0]    wcnt;
    u2                fcode, fcode_n;
    logic [CNT_W-1:0] cnt;
    u1                retire;
    u1                expire;
    u3                rt_alu;
    u1                rt_bad;
    mc_ctl_t          c, co;

    mc_aludec u_aludec (
        .funct   (bus.funct),
        .alucont (rt_alu),
        .illegal (rt_bad)
    );

    // A ready in the expiry cycle completes the access instead.
    assign expire = (MEM_TIMEOUT != 0) && (wcnt == WLAST)
                    && !bus.mem_ready;

    always_comb begin
        state_n = state;
        fcode_n = fcode;
        retire  = 1'b0;
        c       = '0;
        unique case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = SRCB_4;
                c.pcsrc   = PC_ALU;
                c.alucont = ALU_ADD;
                if (bus.mem_ready) begin
                    c.irwrite = 1'b1;
                    c.pcen    = 1'b1;
                    state_n   = S_DECODE;
                end else if (expire) begin
                    state_n = S_FAULT;
                    fcode_n = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.alucont = ALU_ADD;
                unique case (bus.op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_RTEX;
                    OP_BEQ:       state_n = S_BEQEX;
                    OP_BNE:       state_n = S_BNEEX;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JEX;
                    default: begin
                        state_n = S_FAULT;
                        fcode_n = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.alucont = ALU_ADD;
                state_n   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_n = S_MEMWB;
                end else if (expire) begin
                    state_n = S_FAULT;
                    fcode_n = FC_TIMEOUT;
                end
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                state_n    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                if (bus.mem_ready) begin
                    state_n = S_FETCH;
                    retire  = 1'b1;
                end else if (expire) begin
                    state_n = S_FAULT;
                    fcode_n = FC_TIMEOUT;
                end
            end
            S_RTEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.alucont = rt_alu;
                if (rt_bad) begin
                    state_n = S_FAULT;
                    fcode_n = FC_ILLEGAL;
                end else begin
                    state_n = S_RTWB;
                end
            end
            S_RTWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                state_n    = S_FETCH;
                retire     = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.alucont = ALU_SUB;
                c.pcsrc   = PC_ALUOUT;
                c.pcen    = (state == S_BEQEX) ? bus.zero : !bus.zero;
                state_n   = S_FETCH;
                retire    = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.alucont = ALU_ADD;
                state_n   = S_ADDIWB;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
                state_n    = S_FETCH;
                retire     = 1'b1;
            end
            S_JEX: begin
                c.pcsrc = PC_JUMP;
                c.pcen  = 1'b1;
                state_n = S_FETCH;
                retire  = 1'b1;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
            fcode <= FC_NONE;
            wcnt  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            fcode <= fcode_n;
            if (retire)
                cnt <= cnt + 1'b1;
            // Every wait state is entered from a different state.
            if (state_n != state)
                wcnt <= '0;
            else if (is_wait(state) && !bus.mem_ready)
                wcnt <= wcnt + 1'b1;
        end
    end

    // Controls are forced low while reset is held so an interrupted
    // access never leaves a strobe in the reset cycle.
    assign co = reset ? c : '0;

    assign bus.mem_req    = co.mem_req;
    assign bus.pcen       = co.pcen;
    assign bus.irwrite    = co.irwrite;
    assign bus.regwrite   = co.regwrite;
    assign bus.memwrite   = co.memwrite;
    assign bus.iord       = co.iord;
    assign bus.alusrca    = co.alusrca;
    assign bus.memtoreg   = co.memtoreg;
    assign bus.regdst     = co.regdst;
    assign bus.alusrcb    = co.alusrcb;
    assign bus.pcsrc      = co.pcsrc;
    assign bus.alucont    = co.alucont;
    assign bus.fault      = reset && (state == S_FAULT);
    assign bus.fault_code = reset ? fcode : FC_NONE;
    assign bus.instret    = cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Table vectors, hand sequences and random instructions vs. a cycle model.
module tb_mc_ctrl;

    localparam int TO = 4;

    localparam logic [5:0] L_R    = 6'b000000;
    localparam logic [5:0] L_LW   = 6'b100011;
    localparam logic [5:0] L_SW   = 6'b101011;
    localparam logic [5:0] L_BEQ  = 6'b000100;
    localparam logic [5:0] L_BNE  = 6'b000101;
    localparam logic [5:0] L_ADDI = 6'b001000;
    localparam logic [5:0] L_J    = 6'b000010;

    typedef struct packed {
        logic       mem_req;
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucont;
    } ctl_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         wf;
        int         wm;
        int         ncyc;
        logic [1:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;
    int   exp_cnt = 0;
    vec_t tq[$];

    mc_if #(.CNT_W(4)) bus ();

    mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench time limit");
    end

    function automatic ctl_t v(
        logic rq, logic pe, logic ir, logic rw, logic mw,
        logic io, logic sa, logic mr, logic rd,
        logic [1:0] sb, logic [1:0] ps, logic [2:0] al);
        ctl_t c;
        c.mem_req = rq; c.pcen = pe; c.irwrite = ir;
        c.regwrite = rw; c.memwrite = mw; c.iord = io;
        c.alusrca = sa; c.memtoreg = mr; c.regdst = rd;
        c.alusrcb = sb; c.pcsrc = ps; c.alucont = al;
        return c;
    endfunction

    function automatic ctl_t act();
        return v(bus.mem_req, bus.pcen, bus.irwrite,
                 bus.regwrite, bus.memwrite, bus.iord,
                 bus.alusrca, bus.memtoreg, bus.regdst,
                 bus.alusrcb, bus.pcsrc, bus.alucont);
    endfunction

    function automatic ctl_t fetch_e(logic r);
        return v(1, r, r, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    endfunction
    function automatic ctl_t decode_e();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
    endfunction
    function automatic ctl_t memadr_e();
        return v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 3'b010);
    endfunction
    function automatic ctl_t memrd_e();
        return v(1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic ctl_t memwb_e();
        return v(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic ctl_t memwr_e();
        return v(1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic ctl_t rtex_e(logic [2:0] al);
        return v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, al);
    endfunction
    function automatic ctl_t rtwb_e();
        return v(0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic ctl_t br_e(logic p);
        return v(0, p, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 3'b110);
    endfunction
    function automatic ctl_t addiex_e();
        return v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 3'b010);
    endfunction
    function automatic ctl_t addiwb_e();
        return v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic ctl_t jex_e();
        return v(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000);
    endfunction

    function automatic logic [2:0] exp_alu(logic [5:0] f,
                                           output bit bad);
        bad = 1'b0;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin
                bad = 1'b1;
                return 3'b010;
            end
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // One non-fault cycle: drive, compare at negedge, step to posedge+1.
    task automatic cyc(string nm, ctl_t e, logic rdy, logic z);
        bus.mem_ready = rdy;
        bus.zero = z;
        @(negedge clk);
        chk({nm, ".ctl"}, 32'(act()), 32'(e));
        chk({nm, ".flt"}, {bus.fault, bus.fault_code}, 3'b000);
        chk({nm, ".cnt"}, 32'(bus.instret), exp_cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic fault_cycles(logic [1:0] code);
        for (int k = 0; k < 3; k++) begin
            bus.mem_ready = rnd();
            bus.zero = rnd();
            @(negedge clk);
            chk("fault.ctl", 32'(act()), 0);
            chk("fault.flt", {bus.fault, bus.fault_code}, {1'b1, code});
            chk("fault.cnt", 32'(bus.instret), exp_cnt);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("rst.ctl", 32'(act()), 0);
        chk("rst.flt", {bus.fault, bus.fault_code}, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    // Waits w cycles then sees ready; ok=0 on watchdog expiry.
    task automatic waitloop(string nm, ctl_t e, ctl_t er, int w,
                            logic z, inout int cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TO; i++) begin
            cyc(nm, (i == w) ? er : e, i == w, z);
            cycles++;
            if (i == w) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_instr(logic [5:0] o, logic [5:0] f, logic z,
                            int wf, int wm, output int cycles,
                            output logic [1:0] code);
        bit ok;
        bit bad;
        logic [2:0] al;
        cycles = 0;
        code = 2'b00;
        bus.op = o;
        bus.funct = f;
        waitloop("fetch", fetch_e(0), fetch_e(1), wf, z, cycles, ok);
        if (!ok) begin
            code = 2'b10;
            fault_cycles(code);
            return;
        end
        cyc("decode", decode_e(), rnd(), z);
        cycles++;
        case (o)
            L_LW, L_SW: begin
                cyc("memadr", memadr_e(), rnd(), z);
                cycles++;
                if (o == L_LW)
                    waitloop("memrd", memrd_e(), memrd_e(), wm, z,
                             cycles, ok);
                else
                    waitloop("memwr", memwr_e(), memwr_e(), wm, z,
                             cycles, ok);
                if (!ok) begin
                    code = 2'b10;
                    fault_cycles(code);
                    return;
                end
                if (o == L_LW) begin
                    cyc("memwb", memwb_e(), rnd(), z);
                    cycles++;
                end
            end
            L_R: begin
                al = exp_alu(f, bad);
                cyc("rtex", rtex_e(al), rnd(), z);
                cycles++;
                if (bad) begin
                    code = 2'b01;
                    fault_cycles(code);
                    return;
                end
                cyc("rtwb", rtwb_e(), rnd(), z);
                cycles++;
            end
            L_BEQ, L_BNE: begin
                cyc("brex", br_e((o == L_BEQ) ? z : !z), rnd(), z);
                cycles++;
            end
            L_ADDI: begin
                cyc("addiex", addiex_e(), rnd(), z);
                cyc("addiwb", addiwb_e(), rnd(), z);
                cycles += 2;
            end
            L_J: begin
                cyc("jex", jex_e(), rnd(), z);
                cycles++;
            end
            default: begin
                code = 2'b01;
                fault_cycles(code);
                return;
            end
        endcase
        exp_cnt = (exp_cnt + 1) % 16;
    endtask

    task automatic tadd(string nm, logic [5:0] op, logic [5:0] fn,
                        logic z, int wf, int wm, int n,
                        logic [1:0] code);
        vec_t t;
        t.nm = nm; t.op = op; t.fn = fn; t.z = z;
        t.wf = wf; t.wm = wm; t.ncyc = n; t.code = code;
        tq.push_back(t);
    endtask

    initial begin
        int n;
        logic [1:0] code;
        logic [5:0] ops[9];
        logic [5:0] bad_ops[4];
        logic [5:0] fns[6];
        bus.op = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        ops = '{L_LW, L_SW, L_R, L_BEQ, L_BNE, L_ADDI, L_J, L_R, L_J};
        bad_ops = '{6'b111111, 6'b000001, 6'b001111, 6'b110000};
        fns = '{6'b100000, 6'b100010, 6'b100100,
                6'b100101, 6'b101010, 6'b100001};

        tadd("lw",       L_LW,   6'h00, 0, 0, 0,  5, 2'b00);
        tadd("sw_w3",    L_SW,   6'h00, 0, 0, 3,  7, 2'b00);
        tadd("beq_z1",   L_BEQ,  6'h00, 1, 0, 0,  3, 2'b00);
        tadd("beq_z0",   L_BEQ,  6'h00, 0, 0, 0,  3, 2'b00);
        tadd("bne_z1",   L_BNE,  6'h00, 1, 0, 0,  3, 2'b00);
        tadd("bne_z0",   L_BNE,  6'h00, 0, 0, 0,  3, 2'b00);
        tadd("r_add",    L_R,    6'h20, 0, 0, 0,  4, 2'b00);
        tadd("r_slt",    L_R,    6'h2a, 1, 1, 0,  5, 2'b00);
        tadd("addi",     L_ADDI, 6'h00, 0, 0, 0,  4, 2'b00);
        tadd("j",        L_J,    6'h00, 0, 0, 0,  3, 2'b00);
        tadd("j_rdy4",   L_J,    6'h00, 0, 3, 0,  6, 2'b00);
        tadd("lw_w3",    L_LW,   6'h00, 0, 0, 3,  8, 2'b00);
        tadd("fetch_to", L_J,    6'h00, 0, 99, 0, 4, 2'b10);
        tadd("lw_to",    L_LW,   6'h00, 0, 0, 99, 7, 2'b10);
        tadd("sw_to",    L_SW,   6'h00, 0, 0, 99, 7, 2'b10);
        tadd("bad_op",   6'h3f,  6'h00, 0, 0, 0,  2, 2'b01);
        tadd("bad_fn",   L_R,    6'h00, 0, 0, 0,  3, 2'b01);

        @(posedge clk);
        #1;
        do_reset();

        foreach (tq[i]) begin
            do_instr(tq[i].op, tq[i].fn, tq[i].z, tq[i].wf,
                     tq[i].wm, n, code);
            chk({tq[i].nm, ".cycles"}, n, tq[i].ncyc);
            chk({tq[i].nm, ".code"}, 32'(code), 32'(tq[i].code));
            if (code != 2'b00)
                do_reset();
        end

        // Sixteen jumps wrap the 4-bit retired count back to zero.
        do_reset();
        for (int i = 0; i < 16; i++)
            do_instr(L_J, 6'h00, 0, 0, 0, n, code);
        chk("wrap", 32'(bus.instret), 0);

        // Reset while a store waits: no strobe in the reset cycle.
        do_instr(L_ADDI, 6'h00, 0, 0, 0, n, code);
        bus.op = L_SW;
        cyc("hs.fetch", fetch_e(1), 1, 0);
        cyc("hs.decode", decode_e(), 0, 0);
        cyc("hs.memadr", memadr_e(), 0, 0);
        cyc("hs.memwr", memwr_e(), 0, 0);
        do_reset();
        do_instr(L_J, 6'h00, 0, 0, 0, n, code);
        chk("hs.after", n, 3);

        for (int k = 0; k < 150; k++) begin
            logic [5:0] o;
            logic [5:0] f;
            int wf;
            int wm;
            o = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 11) == 0)
                o = bad_ops[$urandom_range(0, 3)];
            f = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0)
                f = fns[5];
            wf = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2)
                                            : $urandom_range(3, 5);
            wm = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2)
                                            : $urandom_range(3, 5);
            do_instr(o, f, rnd(), wf, wm, n, code);
            if (code != 2'b00)
                do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
